// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: load kinds, default widths and
// the tag carried with a staged result.
package wb_stage_pkg;

  localparam int WB_DW         = 32;
  localparam int WB_STARVE_MAX = 4;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  typedef struct packed {
    logic [4:0] rd;
    logic       need;
  } wb_tag_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Little-endian load alignment: picks the addressed byte/half of a memory word
// and sign- or zero-extends it; unknown load kinds pass the word through.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int DW = WB_DW
) (
  input  logic [DW-1:0] word,
  input  logic [2:0]    ld_type,
  input  logic [1:0]    addr_lo,
  output logic [DW-1:0] data
);

  logic signed [7:0]  b;
  logic signed [15:0] h;

  always_comb begin
    b    = word[{addr_lo, 3'b000} +: 8];
    h    = word[{addr_lo[1], 4'b0000} +: 16];
    data = word;
    case (ld_type)
      LD_LB:   data = DW'(b);
      LD_LBU:  data = DW'($unsigned(b));
      LD_LH:   data = DW'(h);
      LD_LHU:  data = DW'($unsigned(h));
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: stages one MEM result, owns the RF write port and shares it
// with a mul/div unit that preempts the pipeline after STARVE_MAX waiting cycles.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DW         = WB_DW,
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_rd,
  input  logic          in_wen,
  input  logic          in_mem2reg,
  input  logic [DW-1:0] in_alu,
  input  logic [DW-1:0] in_mem,
  input  logic [2:0]    in_ld_type,
  input  logic [1:0]    in_addr_lo,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [4:0]    md_rd,
  input  logic [DW-1:0] md_data,
  output logic [4:0]    rf_a3,
  output logic [DW-1:0] rf_wd,
  output logic          rf_wr,
  output logic          fwd_valid,
  output logic [4:0]    fwd_rd,
  output logic [DW-1:0] fwd_data
);

  localparam logic [3:0] WAIT_LIM = 4'(STARVE_MAX);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= WAIT_LIM) ? WAIT_LIM : v + 4'd1;
  endfunction

  logic [DW-1:0] align_p0;
  logic [DW-1:0] data_p0;
  logic          cap_p0;

  logic          vld_p1;
  wb_tag_t       tag_p1;
  logic [DW-1:0] data_p1;
  logic [3:0]    wait_cnt;

  logic          md_grant;
  logic          md_take;
  logic          s_drain;

  // p0: MEM result arrives, load data aligned
  load_align #(.DW(DW)) u_align (
    .word    (in_mem),
    .ld_type (in_ld_type),
    .addr_lo (in_addr_lo),
    .data    (align_p0)
  );

  assign data_p0 = in_mem2reg ? align_p0 : in_alu;
  assign cap_p0  = in_valid && in_ready;

  // Arbitration is purely from registered state plus md_valid.
  assign md_grant = md_valid && (!vld_p1 || !tag_p1.need || wait_cnt == WAIT_LIM);
  assign md_take  = rst_n && md_grant;
  assign s_drain  = vld_p1 && !(tag_p1.need && md_grant);
  assign in_ready = !vld_p1 || s_drain;
  assign md_ready = md_take;

  // p1: staged result, written to the RF unless md preempts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      wait_cnt <= 4'd0;
    end else begin
      if (cap_p0) begin
        vld_p1 <= 1'b1;
      end else if (s_drain) begin
        vld_p1 <= 1'b0;
      end
      wait_cnt <= (md_valid && !md_grant) ? sat_inc(wait_cnt) : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_p0) begin
      tag_p1.rd   <= in_rd;
      tag_p1.need <= in_wen && (in_rd != 5'd0);
      data_p1     <= data_p0;
    end
  end

  always_comb begin
    rf_wr = 1'b0;
    rf_a3 = 5'd0;
    rf_wd = '0;
    if (md_take) begin
      if (md_rd != 5'd0) begin
        rf_wr = 1'b1;
        rf_a3 = md_rd;
        rf_wd = md_data;
      end
    end else if (vld_p1 && tag_p1.need) begin
      rf_wr = 1'b1;
      rf_a3 = tag_p1.rd;
      rf_wd = data_p1;
    end
  end

  always_comb begin
    fwd_valid = vld_p1 && tag_p1.need;
    fwd_rd    = fwd_valid ? tag_p1.rd : 5'd0;
    fwd_data  = fwd_valid ? data_p1 : '0;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cases with literal expectations, then random
// traffic compared every cycle against a behavioural model of the stage.
module tb_wb_stage;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_wen, in_mem2reg;
  logic [4:0]  in_rd;
  logic [31:0] in_alu, in_mem;
  logic [2:0]  in_ld_type;
  logic [1:0]  in_addr_lo;
  logic        md_valid, md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic [4:0]  rf_a3, fwd_rd;
  logic [31:0] rf_wd, fwd_data;
  logic        rf_wr, fwd_valid;

  int total = 0;
  int bad   = 0;

  wb_stage #(.DW(32), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_wen(in_wen),
    .in_mem2reg(in_mem2reg), .in_alu(in_alu), .in_mem(in_mem),
    .in_ld_type(in_ld_type), .in_addr_lo(in_addr_lo),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_wr(rf_wr),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_full = 1'b0;
  logic [4:0]  m_rd   = 5'd0;
  logic        m_need = 1'b0;
  logic [31:0] m_data = 32'd0;
  int          m_wait = 0;

  function automatic logic [31:0] ref_align(input logic [31:0] w, input int t, input int lo);
    logic [31:0] v;
    case (t)
      1, 2: begin
        v = (w >> (8 * lo)) & 32'h0000_00FF;
        if (t == 1 && v[7]) v = v | 32'hFFFF_FF00;
      end
      3, 4: begin
        v = (w >> (16 * (lo / 2))) & 32'h0000_FFFF;
        if (t == 3 && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic m_grant();
    return md_valid && (!m_full || !m_need || m_wait == STARVE);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full <= 1'b0;
      m_wait <= 0;
    end else begin
      if (in_valid && (!m_full || !(m_need && m_grant()))) begin
        m_full <= 1'b1;
        m_rd   <= in_rd;
        m_need <= in_wen && (in_rd != 5'd0);
        m_data <= in_mem2reg ? ref_align(in_mem, int'(in_ld_type), int'(in_addr_lo)) : in_alu;
      end else if (m_full && !(m_need && m_grant())) begin
        m_full <= 1'b0;
      end
      if (md_valid && !m_grant()) m_wait <= (m_wait < STARVE) ? m_wait + 1 : STARVE;
      else m_wait <= 0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic g, ewr, efv;
    logic [4:0]  ea3;
    logic [31:0] ewd;
    g   = rst_n && m_grant();
    efv = rst_n && m_full && m_need;
    ewr = g ? (md_rd != 5'd0) : efv;
    ea3 = g ? md_rd : m_rd;
    ewd = g ? md_data : m_data;
    chk("md_ready", 32'(md_ready), 32'(g));
    chk("rf_wr", 32'(rf_wr), 32'(ewr));
    chk("in_ready", 32'(in_ready), 32'(!m_full || !(m_need && g)));
    chk("fwd_valid", 32'(fwd_valid), 32'(efv));
    if (ewr) begin
      chk("rf_a3", 32'(rf_a3), 32'(ea3));
      chk("rf_wd", rf_wd, ewd);
    end
    if (efv) begin
      chk("fwd_rd", 32'(fwd_rd), 32'(m_rd));
      chk("fwd_data", fwd_data, m_data);
    end
    if (!rst_n) begin
      chk("rst_a3", 32'(rf_a3), 32'd0);
      chk("rst_wd", rf_wd, 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] t, input logic [1:0] lo, input logic [31:0] mem,
                      input logic [4:0] rd, input logic [31:0] want);
    in_valid = 1'b1; in_wen = 1'b1; in_mem2reg = 1'b1;
    in_ld_type = t; in_addr_lo = lo; in_mem = mem; in_rd = rd;
    step();
    in_valid = 1'b0;
    #1;
    chk("load_wr", 32'(rf_wr), 32'd1);
    chk("load_a3", 32'(rf_a3), 32'(rd));
    chk("load_wd", rf_wd, want);
  endtask

  logic acked;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_rd = 5'd0; in_wen = 1'b0; in_mem2reg = 1'b0;
    in_alu = 32'd0; in_mem = 32'd0; in_ld_type = 3'd0; in_addr_lo = 2'd0;
    md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
    #3;
    chk("reset_rf_wr", 32'(rf_wr), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_md_ready", 32'(md_ready), 32'd0);
    chk("reset_fwd_valid", 32'(fwd_valid), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Load alignment
    load(3'd1, 2'd2, 32'h1280_FF34, 5'd5, 32'hFFFF_FF80);
    load(3'd2, 2'd2, 32'h1280_FF34, 5'd5, 32'h0000_0080);
    load(3'd3, 2'd2, 32'h8001_7FFF, 5'd6, 32'hFFFF_8001);
    load(3'd4, 2'd2, 32'h8001_7FFF, 5'd6, 32'h0000_8001);
    load(3'd0, 2'd2, 32'h8001_7FFF, 5'd6, 32'h8001_7FFF);
    step();

    // Back-to-back ALU writes
    in_mem2reg = 1'b0; in_wen = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_alu = 32'(i * 32'h11);
      #1;
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("b2b_a3", 32'(rf_a3), 32'(i));
      chk("b2b_wd", rf_wd, 32'(i * 32'h11));
    end
    in_valid = 1'b0;
    step();

    // Starvation preemption
    in_valid = 1'b1; in_rd = 5'd10; in_alu = 32'hA0;
    step();
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      in_rd = 5'(11 + k); in_alu = 32'(32'hA1 + k);
      #1;
      chk("starve_md_ready", 32'(md_ready), 32'd0);
      chk("starve_pipe_a3", 32'(rf_a3), 32'(10 + k));
      step();
    end
    in_rd = 5'd15; in_alu = 32'hA5;
    #1;
    chk("preempt_md_ready", 32'(md_ready), 32'd1);
    chk("preempt_a3", 32'(rf_a3), 32'd9);
    chk("preempt_wd", rf_wd, 32'hDEAD_BEEF);
    chk("preempt_in_ready", 32'(in_ready), 32'd0);
    chk("preempt_fwd_rd", 32'(fwd_rd), 32'd14);
    chk("preempt_fwd_data", fwd_data, 32'hA4);
    step();
    md_valid = 1'b0;
    #1;
    chk("held_a3", 32'(rf_a3), 32'd14);
    chk("held_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    #1;
    chk("after_a3", 32'(rf_a3), 32'd15);
    step();

    // Register 0 on both sources
    in_valid = 1'b1; in_rd = 5'd0; in_wen = 1'b1; in_alu = 32'h1234;
    step();
    in_valid = 1'b0; md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h5555;
    #1;
    chk("r0_rf_wr", 32'(rf_wr), 32'd0);
    chk("r0_md_ready", 32'(md_ready), 32'd1);
    chk("r0_fwd_valid", 32'(fwd_valid), 32'd0);
    step();
    md_valid = 1'b0;
    #1;
    chk("r0_drained", 32'(in_ready), 32'd1);
    step();

    // Reset mid-stream
    in_valid = 1'b1; in_rd = 5'd7; in_alu = 32'h77;
    step();
    in_rd = 5'd8; md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h33;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rf_wr", 32'(rf_wr), 32'd0);
    chk("midrst_md_ready", 32'(md_ready), 32'd0);
    chk("midrst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    step(); step();
    in_valid = 1'b0; md_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("postrst_rf_wr", 32'(rf_wr), 32'd0);
    step();
    chk("postrst_rf_wr2", 32'(rf_wr), 32'd0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_rd      = 5'($urandom_range(0, 31));
      in_wen     = ($urandom_range(0, 7) != 0);
      in_mem2reg = 1'($urandom_range(0, 1));
      in_alu     = $urandom;
      in_mem     = $urandom;
      in_ld_type = 3'($urandom_range(0, 7));
      in_addr_lo = 2'($urandom_range(0, 3));
      if (!md_valid) begin
        md_valid = ($urandom_range(0, 3) == 0);
        md_rd    = 5'($urandom_range(0, 31));
        md_data  = $urandom;
      end
      #2;
      acked = md_ready;
      step();
      if (acked) md_valid = 1'b0;
    end
    in_valid = 1'b0; md_valid = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
